fm_voice_allocator: RTL and testbench

//  Voice allocator and scheduler for the FM synth channel bank. Accepts a stream of note-on and

---
 rtl/fm_voice_allocator.sv | 144 ++++++++++++++
 tb/tb_fm_voice_allocator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fm_voice_allocator.sv
// fm_voice_allocator: note-on/off voice allocator for the FM channel bank; build with VOICE_STEAL_EN to steal the oldest voice when none is free
// ports: clk, rst (async high); evt_valid/evt_ready/evt_on/evt_note/evt_vel/evt_phase_inc event in;
//        carrier_out/velocity_out per-channel words; voice_active; steal_pulse/drop_pulse 1-cycle flags
module fm_voice_allocator #(
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_BITS     = 32,
  parameter int AGE_BITS     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             evt_valid,
  output logic                             evt_ready,
  input  logic                             evt_on,
  input  logic [6:0]                       evt_note,
  input  logic [6:0]                       evt_vel,
  input  logic [NUM_BITS-1:0]              evt_phase_inc,
  output logic [NUM_CHANNELS*NUM_BITS-1:0] carrier_out,
  output logic [NUM_CHANNELS*NUM_BITS-1:0] velocity_out,
  output logic [NUM_CHANNELS-1:0]          voice_active,
  output logic                             steal_pulse,
  output logic                             drop_pulse
);
  localparam int IW = $clog2(NUM_CHANNELS);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, m_idx, f_idx, tgt;
  logic m_hit, f_hit, key_on, tgt_ok, steal, e_on;
  logic [6:0] e_note, e_vel;
  logic [NUM_BITS-1:0] e_inc;
  logic [AGE_BITS-1:0] seq_cnt;
  logic [6:0] tag [NUM_CHANNELS];
  logic [6:0] vel [NUM_CHANNELS];
  logic [AGE_BITS-1:0] stamp [NUM_CHANNELS];
  logic [NUM_BITS-1:0] carrier [NUM_CHANNELS];
  logic accept;
  assign evt_ready = state == IDLE;
  assign accept = evt_valid && evt_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = evt_valid ? SCAN : IDLE;
    if (state == SCAN) state_nx = idx == IW'(NUM_CHANNELS - 1) ? COMMIT : SCAN;
    if (state == COMMIT) state_nx = IDLE;
  end
`ifdef VOICE_STEAL_EN
  logic o_hit, steal_q;
  logic [IW-1:0] o_idx;
  logic [AGE_BITS-1:0] o_age, age;
  assign age = seq_cnt - stamp[idx];
  assign steal_pulse = steal_q;
  always_comb begin
    key_on = e_on && e_vel != 7'd0;
    steal = key_on && !m_hit && !f_hit;
    tgt = m_hit ? m_idx : f_hit ? f_idx : o_idx;
    tgt_ok = m_hit || (key_on && (f_hit || o_hit));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_hit <= 1'b0;
      o_idx <= '0;
      o_age <= '0;
      steal_q <= 1'b0;
    end else begin
      steal_q <= state == COMMIT && tgt_ok && steal;
      if (accept) o_hit <= 1'b0;
      if (state == SCAN && voice_active[idx] && (!o_hit || age > o_age)) begin
        o_hit <= 1'b1;
        o_idx <= idx;
        o_age <= age;
      end
    end
`else
  assign steal_pulse = 1'b0;
  always_comb begin
    key_on = e_on && e_vel != 7'd0;
    steal = 1'b0;
    tgt = m_hit ? m_idx : f_idx;
    tgt_ok = m_hit || (key_on && f_hit);
  end
`endif
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_out
    assign carrier_out[i*NUM_BITS +: NUM_BITS] = carrier[i];
    assign velocity_out[i*NUM_BITS +: NUM_BITS] = {{(NUM_BITS-7){1'b0}}, vel[i]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      m_hit <= 1'b0;
      f_hit <= 1'b0;
      m_idx <= '0;
      f_idx <= '0;
      e_on <= 1'b0;
      e_note <= '0;
      e_vel <= '0;
      e_inc <= '0;
      seq_cnt <= '0;
      voice_active <= '0;
      drop_pulse <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        tag[c] <= '0;
        vel[c] <= '0;
        stamp[c] <= '0;
        carrier[c] <= '0;
      end
    end else begin
      drop_pulse <= 1'b0;
      if (accept) begin
        idx <= '0;
        m_hit <= 1'b0;
        f_hit <= 1'b0;
        e_on <= evt_on;
        e_note <= evt_note;
        e_vel <= evt_vel;
        e_inc <= evt_phase_inc;
      end
      if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (!m_hit && voice_active[idx] && tag[idx] == e_note) begin
          m_hit <= 1'b1;
          m_idx <= idx;
        end
        if (!f_hit && !voice_active[idx]) begin
          f_hit <= 1'b1;
          f_idx <= idx;
        end
      end
      if (state == COMMIT) begin
        if (!tgt_ok) drop_pulse <= 1'b1;
        else if (key_on) begin
          carrier[tgt] <= e_inc;
          vel[tgt] <= e_vel;
          tag[tgt] <= e_note;
          stamp[tgt] <= seq_cnt;
          voice_active[tgt] <= 1'b1;
          seq_cnt <= seq_cnt + 1'b1;
        end else begin
          vel[tgt] <= '0;
          voice_active[tgt] <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_fm_voice_allocator.sv
// tb_fm_voice_allocator: directed plus randomized events checked against a behavioural voice model
module tb_fm_voice_allocator;
  localparam int NC = 16;
  localparam int NB = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evt_valid = 1'b0;
  logic evt_ready;
  logic evt_on = 1'b0;
  logic [6:0] evt_note = '0;
  logic [6:0] evt_vel = '0;
  logic [NB-1:0] evt_phase_inc = '0;
  logic [NC*NB-1:0] carrier_out, velocity_out;
  logic [NC-1:0] voice_active;
  logic steal_pulse, drop_pulse;
  int vectors = 0;
  int errors = 0;
  bit steal_en;
  bit m_act [NC];
  int m_tag [NC];
  int m_stamp [NC];
  int m_car [NC];
  int m_vel [NC];
  int m_seq;
  bit x_steal, x_drop;
  always #5 clk = ~clk;
  fm_voice_allocator dut (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_on(evt_on),
    .evt_note(evt_note), .evt_vel(evt_vel), .evt_phase_inc(evt_phase_inc),
    .carrier_out(carrier_out), .velocity_out(velocity_out), .voice_active(voice_active),
    .steal_pulse(steal_pulse), .drop_pulse(drop_pulse)
  );
  task automatic check(input string name, input logic [NC*NB-1:0] got, input logic [NC*NB-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_act[i] = 0;
      m_tag[i] = 0;
      m_stamp[i] = 0;
      m_car[i] = 0;
      m_vel[i] = 0;
    end
    m_seq = 0;
  endtask
  function automatic logic [NC*NB-1:0] pack_car();
    logic [NC*NB-1:0] r = '0;
    for (int i = 0; i < NC; i++) r[i*NB +: NB] = m_car[i];
    return r;
  endfunction
  function automatic logic [NC*NB-1:0] pack_vel();
    logic [NC*NB-1:0] r = '0;
    for (int i = 0; i < NC; i++) r[i*NB +: NB] = m_vel[i];
    return r;
  endfunction
  function automatic logic [NC-1:0] pack_act();
    logic [NC-1:0] r = '0;
    for (int i = 0; i < NC; i++) r[i] = m_act[i];
    return r;
  endfunction
  task automatic model_event(input bit on, input int note, input int vel, input int inc);
    int m = -1, f = -1, o = -1, best = -1, t;
    bit key_on = on && vel != 0;
    for (int i = 0; i < NC; i++) begin
      if (m < 0 && m_act[i] && m_tag[i] == note) m = i;
      if (f < 0 && !m_act[i]) f = i;
      if (m_act[i] && ((m_seq - m_stamp[i]) % 256 + 256) % 256 > best) begin
        best = ((m_seq - m_stamp[i]) % 256 + 256) % 256;
        o = i;
      end
    end
    x_steal = 0;
    x_drop = 0;
    if (key_on) begin
      t = m >= 0 ? m : f >= 0 ? f : steal_en ? o : -1;
      if (t < 0) x_drop = 1;
      else begin
        x_steal = m < 0 && f < 0;
        m_car[t] = inc;
        m_vel[t] = vel;
        m_tag[t] = note;
        m_act[t] = 1;
        m_stamp[t] = m_seq;
        m_seq = (m_seq + 1) % 256;
      end
    end else if (m < 0) x_drop = 1;
    else begin
      m_vel[m] = 0;
      m_act[m] = 0;
    end
  endtask
  task automatic do_event(input bit on, input int note, input int vel, input int inc);
    logic [NC-1:0] prev_act;
    int n = 0;
    while (!evt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before", evt_ready, 1);
    @(negedge clk);
    evt_valid = 1'b1;
    evt_on = on;
    evt_note = 7'(note);
    evt_vel = 7'(vel);
    evt_phase_inc = NB'(inc);
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
    evt_on = $urandom_range(0, 1) != 0;
    evt_note = 7'($urandom);
    evt_vel = 7'($urandom);
    evt_phase_inc = $urandom;
    check("ready_drop", evt_ready, 0);
    prev_act = pack_act();
    model_event(on, note, vel, inc);
    repeat (NC) @(posedge clk);
    #1;
    check("latency_hold", voice_active, prev_act);
    check("pulse_idle", {steal_pulse, drop_pulse}, 0);
    @(posedge clk);
    #1;
    check("carrier", carrier_out, pack_car());
    check("velocity", velocity_out, pack_vel());
    check("active", voice_active, pack_act());
    check("steal", steal_pulse, x_steal);
    check("drop", drop_pulse, x_drop);
    check("ready_back", evt_ready, 1);
    @(posedge clk);
    #1;
    check("pulse_clear", {steal_pulse, drop_pulse}, 0);
  endtask
  initial begin
`ifdef VOICE_STEAL_EN
    steal_en = 1;
`else
    steal_en = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_carrier", carrier_out, 0);
    check("rst_velocity", velocity_out, 0);
    check("rst_active", voice_active, 0);
    check("rst_ready", evt_ready, 1);
    check("rst_pulses", {steal_pulse, drop_pulse}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_event(1, 60, 100, 'h1000);
    check("t1_active", voice_active, 16'h0001);
    do_event(1, 62, 90, 'h1100);
    do_event(1, 64, 80, 'h1200);
    check("t2_active", voice_active, 16'h0007);
    do_event(0, 62, 0, 'h5555);
    check("t2_off", voice_active, 16'h0005);
    do_event(1, 60, 70, 'h2000);
    check("t3_retrig", voice_active, 16'h0005);
    do_event(0, 99, 0, 'h0);
    do_event(1, 64, 0, 'h7777);
    check("t5_vel0_off", voice_active, 16'h0001);
    @(negedge clk);
    evt_valid = 1'b1;
    evt_on = 1'b1;
    evt_note = 7'd33;
    evt_vel = 7'd50;
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_carrier", carrier_out, 0);
    check("t6_velocity", velocity_out, 0);
    check("t6_active", voice_active, 0);
    check("t6_ready", evt_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    do_event(1, 33, 50, 'h3300);
    check("t6_ch0", voice_active, 16'h0001);
    do_event(0, 33, 0, 'h0);
    for (int i = 0; i < NC; i++) do_event(1, 40 + i, 10 + i, 'h100 * (i + 1));
    check("t4_full", voice_active, 16'hffff);
    do_event(1, 70, 127, 'hABCD);
    for (int i = 0; i < 70; i++)
      do_event($urandom_range(0, 3) != 0, 40 + $urandom_range(0, 21),
               $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 127), int'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
